// File: rtl/cdc_pkg.sv
// Shared types and helpers for the source side of the bundled-data CDC handshake.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } cdc_src_state_t;

    // Counter must be able to hold TIMEOUT_CYCLES itself so it can saturate there.
    function automatic int wdog_width(input int timeout_cycles);
        return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/cdc_watchdog.sv
// Saturating ack watchdog: pulses o_expired once, in the cycle its count reaches
// TIMEOUT_CYCLES-1 while enabled. TIMEOUT_CYCLES==0 removes the counter.
module cdc_watchdog
    import cdc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic src_clk,
    input  logic aresetn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic w_unused;
            assign w_unused  = ^{src_clk, aresetn, i_clear, i_enable};
            assign o_expired = 1'b0;
        end else begin : g_on
            localparam int            CW     = wdog_width(TIMEOUT_CYCLES);
            localparam logic [CW-1:0] LIMIT  = CW'(TIMEOUT_CYCLES);
            localparam logic [CW-1:0] THRESH = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] r_wdog;

            always_ff @(posedge src_clk) begin
                if (!aresetn || i_clear) begin
                    r_wdog <= '0;
                end else if (i_enable && (r_wdog != LIMIT)) begin
                    r_wdog <= r_wdog + CW'(1);
                end
            end

            assign o_expired = i_enable && (r_wdog == THRESH);
        end
    endgenerate

endmodule

// File: rtl/cdc_handshake_src.sv
// Source-side controller for a bundled-data CDC: captures one word, fires a request
// pulse into a pulse_cdc, and holds the word until the returned ack frees the slot.
module cdc_handshake_src
    import cdc_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              src_clk,
    input  logic              aresetn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [DATA_W-1:0] cdc_data,
    output logic              req_pulse,
    input  logic              ack_pulse,
    output logic              done_pulse,
    output logic              busy,
    input  logic              err_clr,
    output logic              err_timeout,
    output logic              err_spurious
);

    cdc_src_state_t    r_state, w_next;
    logic              w_accept, w_done, w_expired, w_spurious;
    logic              r_req, r_done, r_timeout, r_spurious;
    logic [DATA_W-1:0] r_data;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (s_valid) begin
                    w_accept = 1'b1;
                    w_next   = REQ;
                end
            end
            REQ: w_next = WAIT_ACK;
            WAIT_ACK: begin
                if (ack_pulse) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_spurious = ack_pulse && (r_state != WAIT_ACK);

    cdc_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .src_clk  (src_clk),
        .aresetn  (aresetn),
        .i_clear  (r_state == REQ),
        .i_enable (r_state == WAIT_ACK),
        .o_expired(w_expired)
    );

    // Sticky flags: a set event in the same cycle as err_clr wins; an ack on the
    // threshold cycle completes the transfer instead of flagging a timeout.
    always_ff @(posedge src_clk) begin
        if (!aresetn) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_done     <= 1'b0;
            r_data     <= '0;
            r_timeout  <= 1'b0;
            r_spurious <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_req      <= w_accept;
            r_done     <= w_done;
            if (w_accept) r_data <= s_data;
            r_timeout  <= (w_expired && !ack_pulse) || (r_timeout && !err_clr);
            r_spurious <= w_spurious || (r_spurious && !err_clr);
        end
    end

    assign s_ready      = aresetn && (r_state == IDLE);
    assign busy         = (r_state != IDLE);
    assign cdc_data     = r_data;
    assign req_pulse    = r_req;
    assign done_pulse   = r_done;
    assign err_timeout  = r_timeout;
    assign err_spurious = r_spurious;

endmodule

// File: tb/tb_cdc_handshake_src.sv
// Bench for cdc_handshake_src: directed scenarios then random traffic, every cycle
// compared against a transaction/cycle-count reference model.
module tb_cdc_handshake_src;

    localparam int DW = 32;
    localparam int T  = 8;

    logic          clk = 1'b0;
    logic          aresetn, s_valid, ack_pulse, err_clr;
    logic [DW-1:0] s_data;
    logic          s_ready, req_pulse, done_pulse, busy, err_timeout, err_spurious;
    logic [DW-1:0] cdc_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: one transfer in flight, phases derived from its accept cycle.
    bit          m_busy, m_req, m_done, m_to, m_sp;
    int          m_acc;
    logic [DW-1:0] m_data;

    cdc_handshake_src #(.DATA_W(DW), .TIMEOUT_CYCLES(T)) dut (
        .src_clk     (clk),
        .aresetn     (aresetn),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .cdc_data    (cdc_data),
        .req_pulse   (req_pulse),
        .ack_pulse   (ack_pulse),
        .done_pulse  (done_pulse),
        .busy        (busy),
        .err_clr     (err_clr),
        .err_timeout (err_timeout),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step();
        bit in_wait, nb, set_to, set_sp;
        if (!aresetn) begin
            m_busy = 0; m_req = 0; m_done = 0; m_to = 0; m_sp = 0; m_data = '0;
        end else begin
            in_wait = m_busy && (cyc >= m_acc + 2);
            nb = m_busy; m_req = 0; m_done = 0; set_to = 0; set_sp = 0;
            if (!m_busy && s_valid) begin
                m_data = s_data; m_acc = cyc; nb = 1; m_req = 1;
            end
            if (ack_pulse && !in_wait) set_sp = 1;
            if (in_wait && ack_pulse) begin
                nb = 0; m_done = 1;
            end else if (in_wait && (cyc - (m_acc + 2)) == T - 1) begin
                set_to = 1;
            end
            m_to   = set_to || (m_to && !err_clr);
            m_sp   = set_sp || (m_sp && !err_clr);
            m_busy = nb;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        chk("s_ready", s_ready, aresetn && !m_busy);
        chk("busy", busy, m_busy);
        chk("req_pulse", req_pulse, m_req);
        chk("done_pulse", done_pulse, m_done);
        chk("cdc_data", cdc_data, m_data);
        chk("err_timeout", err_timeout, m_to);
        chk("err_spurious", err_spurious, m_sp);
    endtask

    task automatic wait_req();
        int n = 0;
        while (req_pulse !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("wait_req", req_pulse, 1);
    endtask

    initial begin
        logic [DW-1:0] w;
        aresetn = 0; s_valid = 0; s_data = '0; ack_pulse = 0; err_clr = 0;
        repeat (4) tick();
        chk("rst_ready", s_ready, 0);
        aresetn = 1;
        tick();
        chk("post_rst_ready", s_ready, 1);

        // Single word, late ack
        s_valid = 1; s_data = 32'hA5A5_0001;
        tick();
        s_valid = 0; s_data = $urandom;
        chk("t1_req", req_pulse, 1);
        chk("t1_data", cdc_data, 32'hA5A5_0001);
        chk("t1_ready", s_ready, 0);
        tick();
        chk("t1_req_once", req_pulse, 0);
        repeat (12) tick();
        ack_pulse = 1; tick(); ack_pulse = 0;
        chk("t1_done", done_pulse, 1);
        chk("t1_ready_back", s_ready, 1);
        err_clr = 1; tick(); err_clr = 0;
        tick();

        // Back-to-back words with valid held and a loopback-style ack delay
        s_valid = 1; s_data = 32'h1;
        for (int k = 0; k < 2; k++) begin
            wait_req();
            chk("t2_word", cdc_data, k + 1);
            if (k == 0) s_data = 32'h2; else s_valid = 0;
            repeat (3) tick();
            chk("t2_busy", busy, 1);
            ack_pulse = 1; tick(); ack_pulse = 0;
            chk("t2_done", done_pulse, 1);
        end
        repeat (3) tick();

        // Watchdog expiry, late ack, clear
        s_valid = 1; s_data = $urandom;
        tick(); s_valid = 0;
        tick();
        repeat (7) tick();
        chk("t3_not_yet", err_timeout, 0);
        tick();
        chk("t3_timeout", err_timeout, 1);
        chk("t3_busy", busy, 1);
        repeat (5) tick();
        ack_pulse = 1; tick(); ack_pulse = 0;
        chk("t3_done", done_pulse, 1);
        err_clr = 1; tick(); err_clr = 0;
        chk("t3_clr", err_timeout, 0);

        // Ack on the threshold cycle: completion wins
        s_valid = 1; s_data = $urandom;
        tick(); s_valid = 0;
        tick();
        repeat (7) tick();
        ack_pulse = 1; tick(); ack_pulse = 0;
        chk("t6_done", done_pulse, 1);
        chk("t6_no_to", err_timeout, 0);
        tick();
        chk("t6_no_to_late", err_timeout, 0);

        // Spurious acks in IDLE and REQ
        ack_pulse = 1; tick(); ack_pulse = 0;
        chk("t4_sp_idle", err_spurious, 1);
        chk("t4_no_done", done_pulse, 0);
        err_clr = 1; tick(); err_clr = 0;
        chk("t4_sp_clr", err_spurious, 0);
        w = $urandom;
        s_valid = 1; s_data = w;
        tick(); s_valid = 0;
        ack_pulse = 1; err_clr = 1; tick(); ack_pulse = 0; err_clr = 0;
        chk("t4_sp_req_wins", err_spurious, 1);
        chk("t4_data_kept", cdc_data, w);
        chk("t4_still_busy", busy, 1);
        tick();
        ack_pulse = 1; tick(); ack_pulse = 0;
        chk("t4_done", done_pulse, 1);
        tick();

        // Reset mid-transfer
        s_valid = 1; s_data = $urandom;
        tick(); s_valid = 0;
        repeat (3) tick();
        aresetn = 0;
        repeat (4) tick();
        chk("t5_busy", busy, 0);
        chk("t5_data", cdc_data, 0);
        chk("t5_flags", {err_timeout, err_spurious}, 0);
        aresetn = 1; tick();
        w = $urandom;
        s_valid = 1; s_data = w;
        tick(); s_valid = 0;
        chk("t5_req", req_pulse, 1);
        chk("t5_word", cdc_data, w);
        tick(); tick();
        ack_pulse = 1; tick(); ack_pulse = 0;
        chk("t5_done", done_pulse, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            s_valid   = ($urandom_range(0, 2) != 0);
            s_data    = $urandom;
            ack_pulse = ($urandom_range(0, 5) == 0);
            err_clr   = ($urandom_range(0, 15) == 0);
            tick();
        end
        s_valid = 0; ack_pulse = 0; err_clr = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
